sdram_port_arbiter: RTL

//  Sits between the SDRAM controller's single command port and its users: video line fetch, CPU bus, internal refresh.

---
 rtl/sdram_port_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the SDRAM controller's single command port between three users:
// video line fetch, the CPU bus and internal refresh. It owns the refresh
// interval timer and hands one transaction at a time to the controller.
//
// Arbitration (evaluated only in IDLE), highest priority first:
//   1. refresh debt at its ceiling (urgent refresh)
//   2. video, unless the CPU is waiting and video has already taken
//      VID_MAX grants in a row while the CPU was waiting
//   3. CPU
//   4. any outstanding refresh debt
//
// Transaction flow: IDLE -> ISSUE (ctl_req held until ctl_ack)
//                        -> BUSY (wait ctl_done) -> DONE (ack pulse) -> IDLE
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   vid_req/vid_addr     video burst request (level) and start address
//   vid_ack              1-cycle pulse when the video burst completes
//   cpu_req/we/addr/dqm  CPU request (level), direction, address, byte mask
//   cpu_ack              1-cycle pulse when the CPU transaction completes
//   ctl_req/op/addr/dqm  command to the controller
//                        (op: 00 read, 01 write, 10 video burst, 11 refresh)
//   ctl_ack              controller accepted the command
//   ctl_done             1-cycle pulse: accepted command has finished
//   ref_overrun          sticky: a refresh tick was lost at the debt ceiling
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int REFRESH_CYCLES = 390,
  parameter int MAX_DEBT       = 4,
  parameter int VID_MAX        = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_dqm,
  output logic              cpu_ack,
  output logic              ctl_req,
  output logic [1:0]        ctl_op,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [1:0]        ctl_dqm,
  input  logic              ctl_ack,
  input  logic              ctl_done,
  output logic              ref_overrun
);

  localparam int TIMER_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DEBT_W  = $clog2(MAX_DEBT + 1);
  localparam int RUN_W   = $clog2(VID_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [DEBT_W-1:0]  DEBT_CEIL  = DEBT_W'(MAX_DEBT);
  localparam logic [RUN_W-1:0]   RUN_CEIL   = RUN_W'(VID_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_VIDEO   = 2'b10,
    OP_REFRESH = 2'b11
  } op_t;
  typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_REF} grant_t;

  state_t             state_reg;
  grant_t             grant_reg;
  grant_t             win;
  logic [TIMER_W-1:0] timer_reg;
  logic [DEBT_W-1:0]  debt_reg;
  logic [RUN_W-1:0]   vid_run_reg;
  logic               tick;
  logic               ref_done;

  // ---------------------------------------------------------------------------
  // Refresh interval timer: free-running 0..REFRESH_CYCLES-1, tick on wrap.
  // ---------------------------------------------------------------------------
  assign tick = (timer_reg == TIMER_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      timer_reg <= '0;
    end else if (tick) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh debt. A tick coinciding with a refresh completion cancels out,
  // so that case is neither an increment, a decrement nor a lost tick.
  // ---------------------------------------------------------------------------
  assign ref_done = (state_reg == DONE) && (grant_reg == G_REF);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      debt_reg    <= '0;
      ref_overrun <= 1'b0;
    end else if (tick && !ref_done) begin
      if (debt_reg == DEBT_CEIL) begin
        ref_overrun <= 1'b1;
      end else begin
        debt_reg <= debt_reg + 1'b1;
      end
    end else if (ref_done && !tick && (debt_reg != '0)) begin
      debt_reg <= debt_reg - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority decision; only consumed while the FSM is in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    win = G_NONE;
    if (debt_reg == DEBT_CEIL) begin
      win = G_REF;
    end else if (vid_req && !(cpu_req && (vid_run_reg == RUN_CEIL))) begin
      win = G_VID;
    end else if (cpu_req) begin
      win = G_CPU;
    end else if (debt_reg != '0) begin
      win = G_REF;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered command and ack outputs. The command
  // fields are latched at grant time so requester changes afterwards are
  // invisible to the controller.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      grant_reg   <= G_NONE;
      vid_run_reg <= '0;
      ctl_req     <= 1'b0;
      ctl_op      <= OP_READ;
      ctl_addr    <= '0;
      ctl_dqm     <= 2'b00;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The video run length only matters while the CPU is waiting.
          if (!cpu_req || (win == G_CPU)) begin
            vid_run_reg <= '0;
          end else if ((win == G_VID) && (vid_run_reg != RUN_CEIL)) begin
            vid_run_reg <= vid_run_reg + 1'b1;
          end

          if (win != G_NONE) begin
            grant_reg <= win;
            ctl_req   <= 1'b1;
            state_reg <= ISSUE;
            case (win)
              G_VID: begin
                ctl_op   <= OP_VIDEO;
                ctl_addr <= vid_addr;
                ctl_dqm  <= 2'b00;
              end
              G_CPU: begin
                ctl_op   <= cpu_we ? OP_WRITE : OP_READ;
                ctl_addr <= cpu_addr;
                ctl_dqm  <= cpu_we ? cpu_dqm : 2'b00;
              end
              default: begin
                ctl_op   <= OP_REFRESH;
                ctl_addr <= '0;
                ctl_dqm  <= 2'b00;
              end
            endcase
          end
        end

        ISSUE: begin
          // ctl_done here would be a controller protocol error: ignored.
          if (ctl_ack) begin
            ctl_req   <= 1'b0;
            state_reg <= BUSY;
          end
        end

        BUSY: begin
          if (ctl_done) begin
            vid_ack   <= (grant_reg == G_VID);
            cpu_ack   <= (grant_reg == G_CPU);
            state_reg <= DONE;
          end
        end

        default: begin
          // DONE: ack pulse is visible this cycle; no arbitration here.
          vid_ack   <= 1'b0;
          cpu_ack   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
